// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor: {b_out, diff} = a - b - b_in, one bit per clock,
// LSB first, using a single full-subtractor cell and a registered borrow.
//
// Handshake: start is sampled only in IDLE. An accepted start latches a, b
// and b_in. busy is high for the WIDTH RUN cycles. done pulses for exactly
// one cycle when diff/b_out carry the new result. diff/b_out hold their value
// until the next operation completes. start is ignored while busy or done;
// there is no queueing.
//
// Optional feature (macro SERIAL_SUB_OVF_EN): adds output ovf, the
// two's-complement overflow of a - b - b_in, updated together with diff.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request (sampled in IDLE only)
//   a, b      minuend / subtrahend (WIDTH bits), latched on accepted start
//   b_in      borrow-in, latched on accepted start
//   busy      high while the FSM is in RUN
//   done      one-cycle result-valid pulse
//   diff      registered difference (WIDTH bits), held
//   b_out     registered final borrow, held
//   ovf       (SERIAL_SUB_OVF_EN only) registered signed overflow, held
//   dbg_state current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             bor;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             bor_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs.
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
    assign bor_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
    assign last_bit = (cnt == LAST_BIT);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bor  <= b_in;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    bor    <= bor_next;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    // Publish only on the final bit so diff never shows partials.
                    if (last_bit) begin
                        diff  <= res_next;
                        b_out <= bor_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are shifted away during RUN, so keep copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            // d_bit on the last edge is the result sign bit.
            if (state == RUN && last_bit) begin
                ovf <= (a_msb != b_msb) && (d_bit != a_msb);
            end
        end
    end
`endif

endmodule
